// File: rtl/c1351_pkg.sv
// rtl/c1351_pkg.sv - PS/2 packet field positions, LFSR constants and delta clamp for the C1351 emulator
package c1351_pkg;

    localparam int PS2_W      = 25;
    localparam int BIT_TOGGLE = 24;
    localparam int BIT_XSIGN  = 4;
    localparam int BIT_YSIGN  = 5;
    localparam int BIT_XOVF   = 6;
    localparam int BIT_YOVF   = 7;
    localparam int DX_LSB     = 8;
    localparam int DY_LSB     = 16;

    localparam int              LFSR_W     = 17;
    localparam logic [16:0]     LFSR_SEED  = 17'h00001;
    localparam int              LFSR_TAP_A = 0;
    localparam int              LFSR_TAP_B = 3;

    typedef logic signed [8:0] delta_t;

    // An overflowed axis reports only its direction; take the largest representable step.
    function automatic delta_t clamp_delta(input logic sign, input logic ovf, input logic [7:0] mag);
        if (ovf) begin
            return sign ? delta_t'(9'h101) : delta_t'(9'h0FF);
        end
        return delta_t'({sign, mag});
    endfunction

    function automatic logic [16:0] lfsr_next(input logic [16:0] l);
        return {l[LFSR_TAP_A] ^ l[LFSR_TAP_B], l[16:1]};
    endfunction

endpackage

// File: rtl/c1351_axis.sv
// rtl/c1351_axis.sv - one pot axis: delta clamp and scale, wrapping accumulator, registered pot value
module c1351_axis
    import c1351_pkg::*;
#(
    parameter int POS_W  = 6,
    parameter int FRAC_W = 2
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               stb_i,
    input  logic               sign_i,
    input  logic               ovf_i,
    input  logic [7:0]         mag_i,
    input  logic [1:0]         speed_i,
    input  logic               jitter_i,
    input  logic               force_i,
    output logic [POS_W+1:0]   pot_o
);

    localparam int A     = POS_W + FRAC_W;
    localparam int EXT_W = (A > 12) ? A : 12;

    delta_t                    delta;
    logic signed [EXT_W-1:0]   delta_ext;
    logic [A-1:0]              add_d;
    logic [A-1:0]              add_q;
    logic [A-1:0]              acc_q;
    logic                      stb_q;
    logic [POS_W+1:0]          pot_q;

    assign delta     = clamp_delta(sign_i, ovf_i, mag_i);
    assign delta_ext = EXT_W'(delta);
    assign add_d     = A'(delta_ext <<< speed_i);

    // Speed is captured with the strobe so a later speed change cannot rescale a pending delta.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            stb_q <= 1'b0;
            add_q <= '0;
            acc_q <= '0;
            pot_q <= '1;
        end else begin
            stb_q <= stb_i;
            add_q <= add_d;
            if (stb_q) begin
                acc_q <= acc_q + add_q;
            end
            pot_q <= force_i ? '1 : ~{1'b0, acc_q[A-1:FRAC_W], jitter_i};
        end
    end

    assign pot_o = pot_q;

endmodule

// File: rtl/c1351_multi.sv
// rtl/c1351_multi.sv - multi-port C1351 mouse emulator top; optional C1350 joystick mode under C1351_JOY_EN
module c1351_multi
    import c1351_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int POS_W     = 6,
    parameter int FRAC_W    = 2,
    parameter int JOY_THR   = 2,
    parameter int HOLD_CYC  = 50000
) (
    input  logic                              clk_sys,
    input  logic                              reset_n,
    input  logic [NUM_PORTS*PS2_W-1:0]        ps2_mouse,
    input  logic [1:0]                        speed,
    output logic [NUM_PORTS*(POS_W+2)-1:0]    pot_x,
    output logic [NUM_PORTS*(POS_W+2)-1:0]    pot_y,
    output logic [NUM_PORTS*2-1:0]            button
`ifdef C1351_JOY_EN
    ,
    input  logic                              joy_mode,
    output logic [NUM_PORTS*5-1:0]            joy
`endif
);

    localparam int PW = POS_W + 2;

    logic [LFSR_W-1:0]       lfsr_q;
    logic [NUM_PORTS-1:0]    prev_q;
    logic [NUM_PORTS-1:0]    strobe;
    logic [NUM_PORTS*2-1:0]  button_q;
    logic                    joy_active;
    logic                    unused_bits;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    // prev tracks the toggle even in reset so a toggle seen during reset is never replayed.
    always_ff @(posedge clk_sys) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            prev_q[p]          <= ps2_mouse[PS2_W*p + BIT_TOGGLE];
            button_q[2*p +: 2] <= reset_n ? ps2_mouse[PS2_W*p +: 2] : 2'b00;
        end
    end

    always_comb begin
        strobe      = '0;
        unused_bits = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            strobe[p]   = ps2_mouse[PS2_W*p + BIT_TOGGLE] ^ prev_q[p];
            unused_bits = unused_bits ^ ps2_mouse[PS2_W*p + 2] ^ ps2_mouse[PS2_W*p + 3];
        end
    end

    assign button = button_q;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        c1351_axis #(.POS_W(POS_W), .FRAC_W(FRAC_W)) u_x (
            .clk_sys  (clk_sys),
            .reset_n  (reset_n),
            .stb_i    (strobe[p] & ~joy_active),
            .sign_i   (ps2_mouse[PS2_W*p + BIT_XSIGN]),
            .ovf_i    (ps2_mouse[PS2_W*p + BIT_XOVF]),
            .mag_i    (ps2_mouse[PS2_W*p + DX_LSB +: 8]),
            .speed_i  (speed),
            .jitter_i (lfsr_q[2*p]),
            .force_i  (joy_active),
            .pot_o    (pot_x[PW*p +: PW])
        );
        c1351_axis #(.POS_W(POS_W), .FRAC_W(FRAC_W)) u_y (
            .clk_sys  (clk_sys),
            .reset_n  (reset_n),
            .stb_i    (strobe[p] & ~joy_active),
            .sign_i   (ps2_mouse[PS2_W*p + BIT_YSIGN]),
            .ovf_i    (ps2_mouse[PS2_W*p + BIT_YOVF]),
            .mag_i    (ps2_mouse[PS2_W*p + DY_LSB +: 8]),
            .speed_i  (speed),
            .jitter_i (lfsr_q[2*p + 8]),
            .force_i  (joy_active),
            .pot_o    (pot_y[PW*p +: PW])
        );
    end

`ifdef C1351_JOY_EN
    localparam int CW = $clog2(HOLD_CYC + 1);

    logic [CW-1:0]          cnt_q [NUM_PORTS][4];
    logic [3:0]             hit   [NUM_PORTS];
    delta_t                 jdx   [NUM_PORTS];
    delta_t                 jdy   [NUM_PORTS];
    logic [NUM_PORTS-1:0]   fire_q;

    assign joy_active = joy_mode;

    // hit/cnt index: 0 up, 1 down, 2 left, 3 right; index^1 is the opposite direction.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            jdx[p] = clamp_delta(ps2_mouse[PS2_W*p + BIT_XSIGN], ps2_mouse[PS2_W*p + BIT_XOVF],
                                 ps2_mouse[PS2_W*p + DX_LSB +: 8]);
            jdy[p] = clamp_delta(ps2_mouse[PS2_W*p + BIT_YSIGN], ps2_mouse[PS2_W*p + BIT_YOVF],
                                 ps2_mouse[PS2_W*p + DY_LSB +: 8]);
            hit[p] = {jdx[p] >= JOY_THR, jdx[p] <= -JOY_THR, jdy[p] <= -JOY_THR, jdy[p] >= JOY_THR};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n || !joy_mode) begin
            fire_q <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                for (int d = 0; d < 4; d++) begin
                    cnt_q[p][d] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                fire_q[p] <= ps2_mouse[PS2_W*p];
                for (int d = 0; d < 4; d++) begin
                    if (strobe[p] && hit[p][d]) begin
                        cnt_q[p][d] <= CW'(HOLD_CYC);
                    end else if (strobe[p] && hit[p][d^1]) begin
                        cnt_q[p][d] <= '0;
                    end else if (cnt_q[p][d] != '0) begin
                        cnt_q[p][d] <= cnt_q[p][d] - 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        joy = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            joy[5*p +: 5] = {fire_q[p], cnt_q[p][3] != '0, cnt_q[p][2] != '0,
                             cnt_q[p][1] != '0, cnt_q[p][0] != '0};
        end
    end
`else
    localparam int unused_joy_cfg = JOY_THR + HOLD_CYC;

    assign joy_active = 1'b0;
`endif

endmodule

// File: tb/tb_c1351_multi.sv
// tb/tb_c1351_multi.sv - randomized bench for c1351_multi against an arithmetic position model
module tb_c1351_multi;

    localparam int NP = 2;

    logic        clk_sys   = 1'b0;
    logic        reset_n   = 1'b0;
    logic [49:0] ps2_mouse = '0;
    logic [1:0]  speed     = 2'd2;
    logic [15:0] pot_x;
    logic [15:0] pot_y;
    logic [3:0]  button;
`ifdef C1351_JOY_EN
    logic        joy_mode  = 1'b0;
    logic [9:0]  joy;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk_sys = ~clk_sys;

    c1351_multi #(.NUM_PORTS(NP)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_mouse (ps2_mouse),
        .speed     (speed),
        .pot_x     (pot_x),
        .pot_y     (pot_y),
        .button    (button)
`ifdef C1351_JOY_EN
        ,
        .joy_mode  (joy_mode),
        .joy       (joy)
`endif
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: acc per axis (index 2*port + is_y), delta accepted but not yet summed,
    // last seen toggle bit, and the jitter LFSR as a plain integer.
    int         m_acc  [4];
    int         m_pend [4];
    int         m_prev [NP];
    int         m_lfsr;
    logic [7:0] e_pot  [4];
    logic [3:0] e_btn;

    function automatic int contrib(input logic [24:0] pk, input bit is_y, input int spd);
        int sign, ovf, field, d;
        sign  = is_y ? pk[5] : pk[4];
        ovf   = is_y ? pk[7] : pk[6];
        field = is_y ? int'(pk[23:16]) : int'(pk[15:8]);
        if (ovf != 0) d = (sign != 0) ? -255 : 255;
        else          d = (sign != 0) ? field - 256 : field;
        return (d * (1 << spd)) & 255;
    endfunction

    // Each negedge: advance the model by the posedge just passed (inputs unchanged since), then compare.
    initial begin
        for (int a = 0; a < 4; a++) begin
            m_acc[a]  = 0;
            m_pend[a] = 0;
        end
        for (int p = 0; p < NP; p++) m_prev[p] = 0;
        m_lfsr = 1;
        forever begin
            @(negedge clk_sys);
            for (int p = 0; p < NP; p++) begin
                logic [24:0] pk;
                pk = ps2_mouse[25*p +: 25];
                for (int y = 0; y < 2; y++) begin
                    int a, jit;
                    a   = 2*p + y;
                    jit = (m_lfsr >> ((y != 0) ? 2*p + 8 : 2*p)) & 1;
                    e_pot[a]  = !reset_n ? 8'hFF : 8'(255 - (((m_acc[a] >> 2) & 63) * 2 + jit));
                    m_acc[a]  = !reset_n ? 0 : (m_acc[a] + m_pend[a]) & 255;
                    m_pend[a] = (reset_n && (int'(pk[24]) != m_prev[p])) ? contrib(pk, y[0], int'(speed)) : 0;
                end
                m_prev[p] = int'(pk[24]);
                e_btn[2*p +: 2] = reset_n ? pk[1:0] : 2'b00;
            end
            m_lfsr = !reset_n ? 1 : ((m_lfsr >> 1) | (((m_lfsr ^ (m_lfsr >> 3)) & 1) << 16));
            for (int p = 0; p < NP; p++) begin
                chk($sformatf("pot_x[%0d]", p), 16'(pot_x[8*p +: 8]), 16'(e_pot[2*p]));
                chk($sformatf("pot_y[%0d]", p), 16'(pot_y[8*p +: 8]), 16'(e_pot[2*p+1]));
            end
            chk("button", 16'(button), 16'(e_btn));
`ifdef C1351_JOY_EN
            chk("joy_off", 16'(joy), 16'h0000);
`endif
        end
    end

    logic [NP-1:0] tog = '0;

    task automatic send(input int p, input logic [23:0] body);
        tog[p] = ~tog[p];
        ps2_mouse[25*p +: 25] = {tog[p], body};
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        step(1);
        reset_n = 1'b0;
        step(3);
        reset_n = 1'b1;
    endtask

    initial begin
        // reset: all-ones pots, buttons low
        step(3);
        chk("rst_pot_x", pot_x, 16'hFFFF);
        chk("rst_pot_y", pot_y, 16'hFFFF);
        chk("rst_button", 16'(button), 16'h0000);
        reset_n = 1'b1;
        step(4);
        chk("idle_pos_x0", 16'(pot_x[6:1]), 16'h003F);

        // dx=+5 at speed 2 on port 0; port 1 untouched
        speed = 2'd2;
        send(0, {8'h00, 8'h05, 8'h00});
        step(3);
        #1;
        chk("dx5_pos_x0", 16'(pot_x[6:1]), 16'h003A);
        chk("dx5_pos_y0", 16'(pot_y[6:1]), 16'h003F);
        chk("dx5_pos_x1", 16'(pot_x[14:9]), 16'h003F);

        // dx=-3 wraps from 0 to 61
        do_reset();
        send(0, {8'h00, 8'hFD, 8'h10});
        step(3);
        #1;
        chk("dxm3_wrap", 16'(pot_x[6:1]), 16'h0002);

        // speed 0: four +1 strobes, carry out of the fraction on the fourth
        do_reset();
        speed = 2'd0;
        for (int i = 0; i < 3; i++) begin
            send(0, {8'h00, 8'h01, 8'h00});
            step(1);
        end
        step(3);
        #1;
        chk("frac_3", 16'(pot_x[6:1]), 16'h003F);
        send(0, {8'h00, 8'h01, 8'h00});
        step(3);
        #1;
        chk("frac_4", 16'(pot_x[6:1]), 16'h003E);

        // X overflow with positive sign clamps to +255
        do_reset();
        send(0, {8'h00, 8'h10, 8'h40});
        step(3);
        #1;
        chk("ovf_clamp", 16'(pot_x[6:1]), 16'h0000);

        // simultaneous strobes on both ports
        do_reset();
        speed = 2'd2;
        send(0, {8'h00, 8'h02, 8'h00});
        send(1, {8'h07, 8'h00, 8'h00});
        step(3);
        #1;
        chk("sim_x0", 16'(pot_x[6:1]), 16'h003D);
        chk("sim_y1", 16'(pot_y[14:9]), 16'h0038);

        // randomized traffic with occasional resets, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            step(1);
            reset_n = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 7) == 0) speed = 2'($urandom_range(0, 3));
            for (int p = 0; p < NP; p++) begin
                logic [24:0] pk;
                pk = 25'($urandom);
                pk[24] = ($urandom_range(0, 1) != 0) ? ~ps2_mouse[25*p + 24] : ps2_mouse[25*p + 24];
                ps2_mouse[25*p +: 25] = pk;
            end
        end
        reset_n = 1'b1;
        step(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
